serial_compare: RTL
===================

// Module: serial_compare
// PURPOSE
//  Multicycle bit-serial magnitude comparator; the sequencing stage that feeds the ALU's
//  1-bit compare cell. Walks operands LSB->MSB, one bit per clock, applying the
//  recurrence L_out = (~a&b) | (L_in&~a) | (L_in&b). Produces SLT/SLTU and equality flags
//  for the multicycle datapath's compare and branch paths.
//  Trades latency for area compared with a parallel comparator.
// PARAMETERS
//  WIDTH  32  operand width in bits; legal values are >= 2
// PORTS
//  clk         in   1      single clock; all state updates on rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  start       in   1      request a compare; accepted only when busy==0
//  signed_cmp  in   1      1 = two's-complement compare, 0 = unsigned; sampled with start
//  a           in   WIDTH  operand A; sampled on the accepted start
//  b           in   WIDTH  operand B; sampled on the accepted start
//  busy        out  1      high while in RUN
//  done        out  1      one-cycle pulse: lt/eq are valid and updated
//  lt          out  1      result: a < b
//  eq          out  1      result: a == b
// BEHAVIOUR
//  Reset (rst_n=0, asynchronous):
//   - state=IDLE; busy=0, done=0, lt=0, eq=0.
//   - Internal shift registers, bit counter and L are cleared.
//   - A reset during RUN aborts the operation; no done pulse is issued.
//  FSM states IDLE, RUN, DONE:
//   - IDLE -> RUN when start=1.
//   - RUN  -> DONE after the cycle that processes bit WIDTH-1.
//   - DONE -> RUN when start=1; otherwise DONE -> IDLE.
//  Accept cycle (start=1 in IDLE or DONE):
//   - Latch a, b and signed_cmp into working registers.
//   - Clear the bit counter and the running L; set eq_acc=1.
//  RUN, one bit per cycle, counter i = 0..WIDTH-1:
//   - Take ai = a_reg[i], bi = b_reg[i].
//   - When i == WIDTH-1 and signed_cmp=1, invert both ai and bi. This maps signed
//     order onto unsigned order.
//   - L <= (~ai&bi) | (L&~ai) | (L&bi).
//   - eq_acc <= eq_acc & ~(ai^bi).
//  Latency:
//   - An accept at edge T0 gives RUN for edges T1..T_WIDTH.
//   - DONE (done=1) is in effect during the cycle after edge T_WIDTH, i.e. WIDTH+1 cycles
//     after the start edge.
//   - lt and eq update on entry to DONE only.
//  Output timing and hold:
//   - busy=1 exactly in RUN (WIDTH cycles).
//   - done=1 exactly in DONE (one cycle).
//   - lt and eq hold their last result through IDLE and any later RUN until the next DONE.
//  Boundary conditions:
//   - start while busy=1 is ignored; the operand inputs are don't-care during RUN.
//   - start held high continuously gives back-to-back operations, one every WIDTH+1 cycles.
//   - Input changes after acceptance have no effect on the result.
//   - lt and eq are never both 1.
//   - The bit counter is $clog2(WIDTH) bits wide and does not wrap during RUN.
// TESTING (WIDTH=32)
//  1 unsigned: a=5, b=9 -> busy for exactly 32 cycles; done pulse 33 cycles after the
//    start edge; lt=1, eq=0.
//  2 unsigned: a=0xFFFF_FFFF, b=0x0000_0001 -> lt=0, eq=0.
//    Signed, same operands -> lt=1 (-1 < 1).
//  3 equal: a=b=0x8000_0000 in both signed and unsigned modes -> lt=0, eq=1.
//    Signed: a=0x8000_0000, b=0x7FFF_FFFF -> lt=1.
//  4 start pulsed mid-RUN with new operands -> ignored; the result matches the first
//    operands. Changing a/b during RUN also does not alter the result.
//  5 rst_n low at RUN cycle 10 -> busy, done, lt, eq go to 0 immediately with no done
//    pulse. After release, a fresh start (a=3, b=3) -> eq=1 after 33 cycles.
//  6 start held high, alternating (a=1,b=2) and (a=2,b=1) -> done every 33 cycles;
//    lt toggles 1,0,1,0.

Source files
------------

// File: rtl/serial_compare.sv
// Bit-serial magnitude comparator: walks the latched operands LSB to MSB,
// one bit per clock, and publishes lt/eq on a one-cycle done pulse.
//
// state | meaning
// IDLE  | waiting for start; lt/eq hold the last result
// RUN   | one operand bit processed per cycle, counter 0..WIDTH-1
// DONE  | done=1 for one cycle; a new start here chains straight into RUN
module serial_compare #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_cmp,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             l_q, l_d;
  logic             eq_acc_q, eq_acc_d;
  logic             lt_q, lt_d;
  logic             eq_q, eq_d;

  logic accept;
  logic last_bit;
  logic ai, bi;
  logic l_next, eq_next;

  // Bit-slice datapath: the sign bits are inverted on the final step of a
  // signed compare, which maps two's-complement order onto unsigned order.
  always_comb begin
    last_bit = (cnt_q == LAST_BIT);
    ai       = a_q[cnt_q] ^ (last_bit & sgn_q);
    bi       = b_q[cnt_q] ^ (last_bit & sgn_q);
    l_next   = (~ai & bi) | (l_q & ~ai) | (l_q & bi);
    eq_next  = eq_acc_q & ~(ai ^ bi);
  end

  // Next-state and working-register update.
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sgn_d    = sgn_q;
    cnt_d    = cnt_q;
    l_d      = l_q;
    eq_acc_d = eq_acc_q;
    lt_d     = lt_q;
    eq_d     = eq_q;
    accept   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) accept = 1'b1;
      end
      RUN: begin
        l_d      = l_next;
        eq_acc_d = eq_next;
        if (last_bit) begin
          // results are published only on entry to DONE
          state_d = DONE;
          lt_d    = l_next;
          eq_d    = eq_next;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (start) accept = 1'b1;
        else       state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d  = RUN;
      a_d      = a;
      b_d      = b;
      sgn_d    = signed_cmp;
      cnt_d    = '0;
      l_d      = 1'b0;
      eq_acc_d = 1'b1;
    end
  end

  // State and datapath registers; reset aborts any compare in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sgn_q    <= 1'b0;
      cnt_q    <= '0;
      l_q      <= 1'b0;
      eq_acc_q <= 1'b0;
      lt_q     <= 1'b0;
      eq_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sgn_q    <= sgn_d;
      cnt_q    <= cnt_d;
      l_q      <= l_d;
      eq_acc_q <= eq_acc_d;
      lt_q     <= lt_d;
      eq_q     <= eq_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign lt   = lt_q;
  assign eq   = eq_q;

endmodule
